// File: rtl/sensor_debounce_if.sv
// Bundles the two sensor inputs, the counter clear and all qualified outputs
// that run between the detector front end and the traffic light controller.
interface sensor_debounce_if;
  logic       raw_a;
  logic       raw_b;
  logic       clr;
  logic       ta;
  logic       tb;
  logic [7:0] veh_cnt_a;
  logic [7:0] veh_cnt_b;
  logic       stuck_a;
  logic       stuck_b;

  modport master (
    output raw_a, raw_b, clr,
    input  ta, tb, veh_cnt_a, veh_cnt_b, stuck_a, stuck_b
  );

  modport slave (
    input  raw_a, raw_b, clr,
    output ta, tb, veh_cnt_a, veh_cnt_b, stuck_a, stuck_b
  );
endinterface

// File: rtl/sensor_debounce.sv
// Two-channel car-detector qualifier: synchronize, debounce, minimum-hold and count.
// Define SENSOR_STUCK_DET_EN to build the stuck-high detector with fail-safe request.
module sensor_debounce #(
  parameter int DEB_CYCLES   = 4,
  parameter int HOLD_CYCLES  = 8,
  parameter int STUCK_CYCLES = 255
) (
  input logic               clk,
  input logic               rst,
  sensor_debounce_if.slave  bus
);

  typedef enum logic {
    REQ_IDLE,
    REQ_ACTIVE
  } req_state_t;

  localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);
  localparam logic [7:0] HOLD_MAX = 8'(HOLD_CYCLES);

  logic       raw_w   [2];
  logic       ta_w    [2];
  logic [7:0] veh_w   [2];
  logic       stuck_w [2];

  assign raw_w[0]      = bus.raw_a;
  assign raw_w[1]      = bus.raw_b;
  assign bus.ta        = ta_w[0];
  assign bus.tb        = ta_w[1];
  assign bus.veh_cnt_a = veh_w[0];
  assign bus.veh_cnt_b = veh_w[1];
  assign bus.stuck_a   = stuck_w[0];
  assign bus.stuck_b   = stuck_w[1];

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic       sync_meta;
    logic       sync;
    logic       deb;
    logic       deb_next;
    logic [3:0] deb_cnt;
    logic [3:0] deb_cnt_next;
    req_state_t state;
    req_state_t state_next;
    logic [7:0] hold;
    logic [7:0] hold_next;
    logic       count;
    logic [7:0] veh;
    logic [7:0] veh_next;
    logic       stuck;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_meta <= 1'b0;
        sync      <= 1'b0;
      end else begin
        sync_meta <= raw_w[ch];
        sync      <= sync_meta;
      end
    end

    // Any agreeing sample restarts the count, so only an unbroken run of
    // DEB_CYCLES disagreeing samples flips the debounced level.
    always_comb begin
      deb_next     = deb;
      deb_cnt_next = '0;
      if (sync != deb) begin
        if (deb_cnt == DEB_LAST) begin
          deb_next = ~deb;
        end else begin
          deb_cnt_next = deb_cnt + 4'd1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        deb     <= 1'b0;
        deb_cnt <= '0;
      end else begin
        deb     <= deb_next;
        deb_cnt <= deb_cnt_next;
      end
    end

    // The request follows deb_next so it rises on the same edge as the
    // debounced level; release waits for a saturated hold and a clear stuck flag.
    always_comb begin
      state_next = state;
      hold_next  = hold;
      count      = 1'b0;
      case (state)
        REQ_IDLE: begin
          if (deb_next || stuck) begin
            state_next = REQ_ACTIVE;
            hold_next  = 8'd1;
            count      = ~stuck;
          end
        end
        REQ_ACTIVE: begin
          if (!deb_next && !stuck && (hold == HOLD_MAX)) begin
            state_next = REQ_IDLE;
            hold_next  = '0;
          end else if (hold != HOLD_MAX) begin
            hold_next = hold + 8'd1;
          end
        end
        default: begin
          state_next = REQ_IDLE;
          hold_next  = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state <= REQ_IDLE;
        hold  <= '0;
      end else begin
        state <= state_next;
        hold  <= hold_next;
      end
    end

    always_comb begin
      veh_next = veh + {7'd0, count};
      if (bus.clr) begin
        veh_next = '0;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        veh <= '0;
      end else begin
        veh <= veh_next;
      end
    end

`ifdef SENSOR_STUCK_DET_EN
    localparam logic [7:0] STUCK_MAX  = 8'(STUCK_CYCLES);
    localparam logic [7:0] STUCK_LAST = 8'(STUCK_CYCLES - 1);

    logic [7:0] stuck_cnt;

    // The run counter is left alone by clr, so a sensor still held high
    // re-flags on the next sample after a clear.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        stuck_cnt <= '0;
        stuck     <= 1'b0;
      end else begin
        if (!sync) begin
          stuck_cnt <= '0;
        end else if (stuck_cnt != STUCK_MAX) begin
          stuck_cnt <= stuck_cnt + 8'd1;
        end
        if (bus.clr) begin
          stuck <= 1'b0;
        end else if (sync && (stuck_cnt >= STUCK_LAST)) begin
          stuck <= 1'b1;
        end
      end
    end
`else
    assign stuck = 1'b0;
`endif

    assign ta_w[ch]    = (state == REQ_ACTIVE);
    assign veh_w[ch]   = veh;
    assign stuck_w[ch] = stuck;
  end

endmodule

// File: tb/tb_sensor_debounce.sv
// Randomized and directed bench for sensor_debounce against a history-based
// reference model; honours SENSOR_STUCK_DET_EN the same way the design does.
module tb_sensor_debounce;

  localparam int DEB   = 4;
  localparam int HOLD  = 8;
  localparam int STUCK = 32;
  localparam int HIST  = 16384;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int errors = 0;

  sensor_debounce_if bus();

  sensor_debounce #(
    .DEB_CYCLES   (DEB),
    .HOLD_CYCLES  (HOLD),
    .STUCK_CYCLES (STUCK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model keeps the full sample history per channel and decides each output
  // from timestamps (last toggle, last low sample, last request rise).
  bit raw_hist [2][HIST];
  bit seen     [2][HIST];
  int n_edge = 0;
  bit m_deb   [2] = '{1'b0, 1'b0};
  bit m_ta    [2] = '{1'b0, 1'b0};
  bit m_stuck [2] = '{1'b0, 1'b0};
  int m_veh    [2] = '{0, 0};
  int last_tog [2] = '{-1, -1};
  int last_low [2] = '{-1, -1};
  int rise_n   [2] = '{0, 0};

  task automatic modelReset();
    n_edge = 0;
    for (int c = 0; c < 2; c++) begin
      m_deb[c]    = 1'b0;
      m_ta[c]     = 1'b0;
      m_stuck[c]  = 1'b0;
      m_veh[c]    = 0;
      last_tog[c] = -1;
      last_low[c] = -1;
      rise_n[c]   = 0;
    end
  endtask

  task automatic modelStep();
    bit raw_now [2];
    raw_now[0] = bus.raw_a;
    raw_now[1] = bus.raw_b;
    for (int c = 0; c < 2; c++) begin
      bit s;
      bit all_diff;
      bit hit;
      bit st;
      bit new_ta;
      int counted;
      s = (n_edge >= 2) ? raw_hist[c][n_edge-2] : 1'b0;
      raw_hist[c][n_edge] = raw_now[c];
      seen[c][n_edge]     = s;
      if (!s) last_low[c] = n_edge;
      hit = s && ((n_edge - last_low[c]) >= STUCK);
      all_diff = ((n_edge - last_tog[c]) >= DEB);
      for (int k = 0; k < DEB; k++) begin
        if (all_diff && (seen[c][n_edge-k] == m_deb[c])) all_diff = 1'b0;
      end
      if (all_diff) begin
        m_deb[c]    = !m_deb[c];
        last_tog[c] = n_edge;
      end
      st = m_stuck[c];
      if (!m_ta[c]) begin
        new_ta  = m_deb[c] || st;
        counted = (new_ta && !st) ? 1 : 0;
        if (new_ta) rise_n[c] = n_edge;
      end else begin
        new_ta  = m_deb[c] || st || ((n_edge - rise_n[c]) < HOLD);
        counted = 0;
      end
      m_ta[c]  = new_ta;
      m_veh[c] = bus.clr ? 0 : (m_veh[c] + counted) % 256;
`ifdef SENSOR_STUCK_DET_EN
      m_stuck[c] = bus.clr ? 1'b0 : (st || hit);
`else
      m_stuck[c] = 1'b0;
      if (hit) m_stuck[c] = 1'b0;
`endif
    end
    if (n_edge < HIST - 1) n_edge++;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) modelReset();
    else      modelStep();
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("ta",        {31'd0, bus.ta},      {31'd0, m_ta[0]});
    checkOutput("tb",        {31'd0, bus.tb},      {31'd0, m_ta[1]});
    checkOutput("veh_cnt_a", {24'd0, bus.veh_cnt_a}, 32'(m_veh[0]));
    checkOutput("veh_cnt_b", {24'd0, bus.veh_cnt_b}, 32'(m_veh[1]));
    checkOutput("stuck_a",   {31'd0, bus.stuck_a}, {31'd0, m_stuck[0]});
    checkOutput("stuck_b",   {31'd0, bus.stuck_b}, {31'd0, m_stuck[1]});
  endtask

  // Called at a falling edge; drives for n rising edges, checking after each.
  task automatic applyStimulus(input bit a, input bit b, input bit c, input int n);
    for (int i = 0; i < n; i++) begin
      bus.raw_a = a;
      bus.raw_b = b;
      bus.clr   = c;
      @(posedge clk);
      @(negedge clk);
      compareAll();
    end
  endtask

  initial begin
    int ta_hi;
    bit ra;
    bit rb;
    bus.raw_a = 1'b0;
    bus.raw_b = 1'b0;
    bus.clr   = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    compareAll();
    checkOutput("rst_ta",    {31'd0, bus.ta}, 32'd0);
    checkOutput("rst_veh_a", {24'd0, bus.veh_cnt_a}, 32'd0);
    rst = 1'b1;

    applyStimulus(1'b0, 1'b0, 1'b0, 10);

    // Held press: request after the debounce latency, one vehicle, B quiet.
    applyStimulus(1'b1, 1'b0, 1'b0, 12);
    checkOutput("press_ta",    {31'd0, bus.ta}, 32'd1);
    checkOutput("press_tb",    {31'd0, bus.tb}, 32'd0);
    checkOutput("press_veh_a", {24'd0, bus.veh_cnt_a}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 20);
    checkOutput("release_ta", {31'd0, bus.ta}, 32'd0);

    // Three-sample glitch must not register.
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 15);
    checkOutput("glitch_veh_a", {24'd0, bus.veh_cnt_a}, 32'd1);

    // Short press: request is stretched to exactly HOLD cycles.
    ta_hi = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus((i < 6), 1'b0, 1'b0, 1);
      if (bus.ta) ta_hi++;
    end
    checkOutput("hold_len",    32'(ta_hi), 32'(HOLD));
    checkOutput("short_veh_a", {24'd0, bus.veh_cnt_a}, 32'd2);

    // 256 clean B pulses wrap the counter back to zero.
    for (int p = 0; p < 256; p++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 5);
      applyStimulus(1'b0, 1'b0, 1'b0, $urandom_range(4, 8));
    end
    checkOutput("wrap_veh_b", {24'd0, bus.veh_cnt_b}, 32'd0);
    checkOutput("wrap_veh_a", {24'd0, bus.veh_cnt_a}, 32'd2);
    for (int p = 0; p < 10; p++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 5);
      applyStimulus(1'b0, 1'b0, 1'b0, 6);
    end
    checkOutput("ten_veh_b", {24'd0, bus.veh_cnt_b}, 32'd10);
    applyStimulus(1'b0, 1'b1, 1'b0, 7);
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    checkOutput("clr_veh_b", {24'd0, bus.veh_cnt_b}, 32'd0);
    checkOutput("clr_tb",    {31'd0, bus.tb}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 20);

    // Sensor held high long enough to be declared stuck.
    applyStimulus(1'b1, 1'b0, 1'b0, 40);
    applyStimulus(1'b0, 1'b0, 1'b0, 10);
`ifdef SENSOR_STUCK_DET_EN
    checkOutput("stuck_set", {31'd0, bus.stuck_a}, 32'd1);
    checkOutput("stuck_ta",  {31'd0, bus.ta}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 5);
    checkOutput("stuck_clr", {31'd0, bus.stuck_a}, 32'd0);
    checkOutput("stuck_clr_ta", {31'd0, bus.ta}, 32'd0);
`else
    checkOutput("stuck_off", {31'd0, bus.stuck_a}, 32'd0);
    checkOutput("stuck_off_ta", {31'd0, bus.ta}, 32'd0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 10);

    // Reset in the middle of a hold discards all progress.
    applyStimulus(1'b1, 1'b0, 1'b0, 8);
    checkOutput("midhold_ta", {31'd0, bus.ta}, 32'd1);
    #2 rst = 1'b0;
    #1;
    compareAll();
    checkOutput("async_rst_ta",    {31'd0, bus.ta}, 32'd0);
    checkOutput("async_rst_veh_a", {24'd0, bus.veh_cnt_a}, 32'd0);
    checkOutput("async_rst_veh_b", {24'd0, bus.veh_cnt_b}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, DEB + 2);
    checkOutput("post_rst_ta",    {31'd0, bus.ta}, 32'd1);
    checkOutput("post_rst_veh_a", {24'd0, bus.veh_cnt_a}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 20);

    // Random traffic on both streets with occasional clears.
    ra = 1'b0;
    rb = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) ra = !ra;
      if ($urandom_range(0, 5) == 0) rb = !rb;
      applyStimulus(ra, rb, ($urandom_range(0, 59) == 0), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sensor_debounce.md
SENSOR_DEBOUNCE -- requirements
Module: sensor_debounce

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4: consecutive stable synchronized samples needed to change a debounced level (range 1..15).
REQ-002 SHALL have parameter HOLD_CYCLES, default 8: minimum cycles ta/tb stay high once asserted (range 1..255).
REQ-003 SHALL have parameter STUCK_CYCLES, default 255: consecutive high synchronized samples that declare a sensor stuck (range 16..255).
REQ-004 Port: clk  input  1  single clock; all state updates on posedge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-low.
REQ-006 Port: raw_a  input  1  asynchronous car detector, street A.
REQ-007 Port: raw_b  input  1  asynchronous car detector, street B.
REQ-008 Port: clr  input  1  synchronous clear of vehicle counters and stuck flags.
REQ-009 Port: ta  output  1  qualified traffic request, street A, to the light controller.
REQ-010 Port: tb  output  1  qualified traffic request, street B, to the light controller.
REQ-011 Port: veh_cnt_a  output  8  count of ta rising edges, wraps 255->0.
REQ-012 Port: veh_cnt_b  output  8  count of tb rising edges, wraps 255->0.
REQ-013 Port: stuck_a  output  1  sticky stuck-high flag, street A.
REQ-014 Port: stuck_b  output  1  sticky stuck-high flag, street B.

Function
REQ-015 Channels A and B SHALL be identical and fully independent; rules below stated for A.
REQ-016 raw_a SHALL pass a 2-flop synchronizer; sync_a = second flop.
REQ-017 Debouncer: state deb_a plus counter; counter clears when sync_a == deb_a, else increments; deb_a SHALL toggle on the edge where counter reaches DEB_CYCLES-1 with sync_a still != deb_a, and counter clears.
REQ-018 Latency: raw_a high at edge N and held -> deb_a (and ta, if no hold pending) = 1 after edge N+DEB_CYCLES+1.
REQ-019 Glitch shorter than DEB_CYCLES synchronized samples SHALL NOT change deb_a.
REQ-020 ta SHALL rise on the same edge deb_a rises; hold counter loads 1 on that edge, increments each cycle ta=1, saturates at HOLD_CYCLES.
REQ-021 ta SHALL fall only when deb_a=0 and hold counter == HOLD_CYCLES; if deb_a falls earlier, ta stays 1 until hold saturates, then falls same edge.
REQ-022 If deb_a returns to 1 while ta is still held, ta SHALL remain 1 with no new rising edge and no count.
REQ-023 veh_cnt_a SHALL increment by 1 on each ta 0->1 edge, wrapping 255->0.
REQ-024 clr=1 SHALL zero veh_cnt_a/b and stuck_a/b next edge; a same-edge ta rising edge is not counted (clr wins); clr SHALL NOT affect synchronizer, debouncer, hold or ta/tb.

Reset
REQ-025 rst=0 SHALL immediately clear synchronizers, debounce/hold/stuck counters, deb_a/b, ta, tb, veh_cnt_a/b, stuck_a/b to 0.
REQ-026 Reset mid-debounce or mid-hold SHALL discard progress; after release a held-high raw input needs full REQ-018 latency again.
REQ-027 Reset release is synchronous to clk by the surrounding system; no internal release synchronizer.

Configuration
REQ-028 Macro SENSOR_STUCK_DET_EN SHALL enable stuck detection.
REQ-029 Defined: counter counts consecutive cycles sync_a=1 (saturating); reaching STUCK_CYCLES sets stuck_a sticky until clr or reset; while stuck_a=1 ta SHALL be forced 1 (fail-safe service), no further veh_cnt_a increments.
REQ-030 Not defined: stuck logic absent; stuck_a/stuck_b tied 0; ports remain.

Verification (DEB_CYCLES=4, HOLD_CYCLES=8, STUCK_CYCLES=32)
REQ-031 raw_a 0->1 sampled at edge 10, held -> ta=1 after edge 15, veh_cnt_a=1; tb stays 0.
REQ-032 raw_a high pulse of 3 cycles -> ta never rises, veh_cnt_a unchanged.
REQ-033 raw_a high 6 cycles then low -> ta high exactly 8 cycles from rise, then 0; veh_cnt_a=1.
REQ-034 256 clean raw_b pulses -> veh_cnt_b wraps to 0; assert clr mid-sequence -> veh_cnt_b=0 next edge, tb unaffected.
REQ-035 With SENSOR_STUCK_DET_EN, raw_a held 40 cycles -> stuck_a=1 after 32nd high synchronized sample, ta=1 after raw_a drops; clr -> stuck_a=0, ta falls per REQ-021; without macro stuck_a stays 0.
REQ-036 rst pulsed low mid-hold (ta=1, hold count 3) -> ta=0, counters 0 immediately; raw_a still high -> ta=1 after 5 edges post-release.
